// File: rtl/fft_framer_pkg.sv
// Shared types and helpers for the FFT stream framer: state encoding,
// the default FFT config word and a signed saturating truncation.
package fft_framer_pkg;

   typedef enum logic [1:0] {
      CFG    = 2'd0,
      FILL   = 2'd1,
      STREAM = 2'd2
   } framer_state_t;

   localparam logic [15:0] CFG_WORD_DEFAULT = 16'h0001;

   // Clamp a signed value into the range of a w-bit two's complement number.
   function automatic logic signed [31:0] sat_trunc(input logic signed [31:0] x,
                                                    input int                 w);
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      hi = (32'sd1 <<< (w - 1)) - 32'sd1;
      lo = -(32'sd1 <<< (w - 1));
      if (x > hi) return hi;
      if (x < lo) return lo;
      return x;
   endfunction

endpackage

// File: rtl/framer_ram.sv
// Simple dual-port sample RAM: one write port, one read port with a
// registered output that holds its value while re_i is low.
module framer_ram #(
   parameter int DEPTH = 256,
   parameter int W     = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [W-1:0]  wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [W-1:0]  rdata_o
);

   logic [W-1:0] mem_q [DEPTH];
   logic [W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_stream_framer.sv
// Speech-stream framer for the FFT core: circular sample buffer, overlapping
// NFFT-sample frames on an AXI4-Stream master, one-shot config word.
// Define FRAMER_PREEMPH_EN to apply first-order pre-emphasis before storage.
module fft_stream_framer
   import fft_framer_pkg::*;
#(
   parameter int          NFFT     = 256,
   parameter int          HOP      = 128,
   parameter int          SAMPLE_W = 16,
   parameter int          DATA_W   = 32,
   parameter logic [15:0] CFG_WORD = CFG_WORD_DEFAULT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [SAMPLE_W-1:0]   s_sample,
   input  logic                  s_valid,
   output logic                  s_ready,
   output logic [15:0]           cfg_tdata,
   output logic                  cfg_tvalid,
   input  logic                  cfg_tready,
   output logic [2*DATA_W-1:0]   m_tdata,
   output logic                  m_tvalid,
   input  logic                  m_tready,
   output logic                  m_tlast,
   output logic [15:0]           frame_count,
   output logic                  busy
);

   localparam int          AW     = $clog2(NFFT);
   localparam logic [AW:0] NFFT_C = (AW + 1)'(NFFT);
   localparam logic [AW:0] HOP_C  = (AW + 1)'(HOP);

   framer_state_t         state_q, state_d;
   logic [AW-1:0]         wptr_q, wptr_d;
   logic [AW-1:0]         rptr_q, rptr_d;
   logic [AW:0]           new_cnt_q, new_cnt_d;
   logic [AW:0]           iss_cnt_q, iss_cnt_d;
   logic                  primed_q, primed_d;
   logic                  rv_q, rv_d;
   logic                  rlast_q, rlast_d;
   logic                  mv_q, mv_d;
   logic                  ml_q, ml_d;
   logic [SAMPLE_W-1:0]   md_q, md_d;
   logic [15:0]           fc_q, fc_d;

   logic                  wr_en;
   logic                  re;
   logic                  out_ready;
   logic [AW:0]           target;
   logic [SAMPLE_W-1:0]   wr_data;
   logic [SAMPLE_W-1:0]   rd_data;

   assign s_ready   = (state_q == FILL);
   assign wr_en     = s_valid && s_ready;
   assign target    = primed_q ? HOP_C : NFFT_C;
   assign out_ready = !mv_q || m_tready;

`ifdef FRAMER_PREEMPH_EN
   logic signed [SAMPLE_W-1:0] x_s;
   logic signed [SAMPLE_W-1:0] xprev_q;
   logic signed [SAMPLE_W+1:0] pe_sum;

   assign x_s     = s_sample;
   assign pe_sum  = (SAMPLE_W + 2)'(x_s) - (SAMPLE_W + 2)'(xprev_q)
                  + (SAMPLE_W + 2)'(xprev_q >>> 5);
   assign wr_data = SAMPLE_W'(sat_trunc(32'(pe_sum), SAMPLE_W));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) xprev_q <= '0;
      else if (wr_en) xprev_q <= x_s;
   end
`else
   assign wr_data = s_sample;
`endif

   framer_ram #(
      .DEPTH (NFFT),
      .W     (SAMPLE_W),
      .AW    (AW)
   ) u_ram (
      .clk     (clk),
      .we_i    (wr_en),
      .waddr_i (wptr_q),
      .wdata_i (wr_data),
      .re_i    (re),
      .raddr_i (rptr_q),
      .rdata_o (rd_data)
   );

   // Read path is two stages: RAM output register (rv_q) feeding the output
   // register (mv_q); each stage advances only when the one after it can take data.
   always_comb begin
      state_d   = state_q;
      wptr_d    = wptr_q;
      rptr_d    = rptr_q;
      new_cnt_d = new_cnt_q;
      iss_cnt_d = iss_cnt_q;
      primed_d  = primed_q;
      rv_d      = rv_q;
      rlast_d   = rlast_q;
      mv_d      = mv_q;
      ml_d      = ml_q;
      md_d      = md_q;
      fc_d      = fc_q;
      re        = 1'b0;
      case (state_q)
         CFG: begin
            if (cfg_tready) state_d = FILL;
         end
         FILL: begin
            if (wr_en) begin
               wptr_d = wptr_q + 1'b1;
               if (new_cnt_q + 1'b1 == target) begin
                  new_cnt_d = '0;
                  primed_d  = 1'b1;
                  rptr_d    = wptr_q + 1'b1;
                  iss_cnt_d = '0;
                  state_d   = STREAM;
               end else begin
                  new_cnt_d = new_cnt_q + 1'b1;
               end
            end
         end
         STREAM: begin
            re = (iss_cnt_q != NFFT_C) && (!rv_q || out_ready);
            if (re) begin
               rptr_d    = rptr_q + 1'b1;
               iss_cnt_d = iss_cnt_q + 1'b1;
               rlast_d   = (iss_cnt_q == NFFT_C - 1'b1);
               rv_d      = 1'b1;
            end else if (out_ready) begin
               rv_d = 1'b0;
            end
            if (out_ready) begin
               mv_d = rv_q;
               ml_d = rv_q && rlast_q;
               if (rv_q) md_d = rd_data;
            end
            if (mv_q && m_tready && ml_q) begin
               fc_d    = fc_q + 16'd1;
               state_d = FILL;
            end
         end
         default: state_d = CFG;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= CFG;
         wptr_q    <= '0;
         rptr_q    <= '0;
         new_cnt_q <= '0;
         iss_cnt_q <= '0;
         primed_q  <= 1'b0;
         rv_q      <= 1'b0;
         rlast_q   <= 1'b0;
         mv_q      <= 1'b0;
         ml_q      <= 1'b0;
         md_q      <= '0;
         fc_q      <= '0;
      end else begin
         state_q   <= state_d;
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         new_cnt_q <= new_cnt_d;
         iss_cnt_q <= iss_cnt_d;
         primed_q  <= primed_d;
         rv_q      <= rv_d;
         rlast_q   <= rlast_d;
         mv_q      <= mv_d;
         ml_q      <= ml_d;
         md_q      <= md_d;
         fc_q      <= fc_d;
      end
   end

   assign cfg_tvalid  = (state_q == CFG);
   assign cfg_tdata   = CFG_WORD;
   assign m_tvalid    = mv_q;
   assign m_tlast     = ml_q;
   assign m_tdata     = {{DATA_W{1'b0}}, DATA_W'($signed(md_q))};
   assign frame_count = fc_q;
   assign busy        = (state_q == STREAM);

endmodule

// File: tb/tb_fft_stream_framer.sv
// Directed bench for fft_stream_framer: instance A (NFFT=8, HOP=4) and
// instance B (NFFT=8, HOP=8), selected one at a time through sel.
module tb_fft_stream_framer;

   localparam int NFFT = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] s_sample = '0;
   logic        s_valid = 1'b0;
   logic        cfg_tready = 1'b0;
   logic        m_tready = 1'b0;
   logic        sel = 1'b0;

   logic        a_s_ready, a_cfg_tvalid, a_m_tvalid, a_m_tlast, a_busy;
   logic [15:0] a_cfg_tdata, a_frame_count;
   logic [63:0] a_m_tdata;
   logic        b_s_ready, b_cfg_tvalid, b_m_tvalid, b_m_tlast, b_busy;
   logic [15:0] b_cfg_tdata, b_frame_count;
   logic [63:0] b_m_tdata;

   logic        o_s_ready, o_cfg_tvalid, o_m_tvalid, o_m_tlast, o_busy;
   logic [15:0] o_cfg_tdata, o_frame_count;
   logic [63:0] o_m_tdata;

   int          n_vec = 0;
   int          n_err = 0;
   int          cyc;
   logic [15:0] hist[$];
   logic [15:0] xp;
   logic [63:0] cap[NFFT];

   always #5 clk = ~clk;

   fft_stream_framer #(
      .NFFT(8), .HOP(4), .SAMPLE_W(16), .DATA_W(32), .CFG_WORD(16'h0001)
   ) dut_a (
      .clk(clk), .reset(reset),
      .s_sample(s_sample), .s_valid(s_valid && !sel), .s_ready(a_s_ready),
      .cfg_tdata(a_cfg_tdata), .cfg_tvalid(a_cfg_tvalid), .cfg_tready(cfg_tready),
      .m_tdata(a_m_tdata), .m_tvalid(a_m_tvalid), .m_tready(m_tready && !sel),
      .m_tlast(a_m_tlast), .frame_count(a_frame_count), .busy(a_busy)
   );

   fft_stream_framer #(
      .NFFT(8), .HOP(8), .SAMPLE_W(16), .DATA_W(32), .CFG_WORD(16'h0001)
   ) dut_b (
      .clk(clk), .reset(reset),
      .s_sample(s_sample), .s_valid(s_valid && sel), .s_ready(b_s_ready),
      .cfg_tdata(b_cfg_tdata), .cfg_tvalid(b_cfg_tvalid), .cfg_tready(cfg_tready),
      .m_tdata(b_m_tdata), .m_tvalid(b_m_tvalid), .m_tready(m_tready && sel),
      .m_tlast(b_m_tlast), .frame_count(b_frame_count), .busy(b_busy)
   );

   assign o_s_ready     = sel ? b_s_ready     : a_s_ready;
   assign o_cfg_tvalid  = sel ? b_cfg_tvalid  : a_cfg_tvalid;
   assign o_cfg_tdata   = sel ? b_cfg_tdata   : a_cfg_tdata;
   assign o_m_tdata     = sel ? b_m_tdata     : a_m_tdata;
   assign o_m_tvalid    = sel ? b_m_tvalid    : a_m_tvalid;
   assign o_m_tlast     = sel ? b_m_tlast     : a_m_tlast;
   assign o_frame_count = sel ? b_frame_count : a_frame_count;
   assign o_busy        = sel ? b_busy        : a_busy;

   // Value the framer is expected to store for input x given previous input xp.
   function automatic logic [15:0] stored(input logic [15:0] x, input logic [15:0] p);
`ifdef FRAMER_PREEMPH_EN
      int v;
      v = int'($signed(x)) - int'($signed(p)) + (int'($signed(p)) >>> 5);
      if (v > 32767) v = 32767;
      if (v < -32768) v = -32768;
      return 16'(v);
`else
      return x + 16'(p & 16'h0);
`endif
   endfunction

   function automatic logic [63:0] word_of(input logic [15:0] s);
      return {32'h0, {16{s[15]}}, s};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      hist.delete();
      xp = '0;
   endtask

   task automatic push(input logic [15:0] x);
      int t;
      t = 0;
      while (!o_s_ready && t < 64) begin
         tick();
         t++;
      end
      chk("push_ready", 64'(o_s_ready), 64'd1);
      s_sample = x;
      s_valid  = 1'b1;
      tick();
      s_valid  = 1'b0;
      hist.push_back(stored(x, xp));
      xp = x;
      if (hist.size() > NFFT) void'(hist.pop_front());
   endtask

   task automatic collect(input int nw, input bit rnd, output int cycles);
      logic [15:0] ef[$];
      int          got;
      int          budget;
      bit          holding;
      logic [63:0] hd;
      logic        hl;
      ef = hist;
      got = 0;
      budget = 0;
      holding = 1'b0;
      hd = '0;
      hl = 1'b0;
      while (got < nw && budget < 500) begin
         m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (holding) begin
            chk("stall_valid", 64'(o_m_tvalid), 64'd1);
            chk("stall_data", o_m_tdata, hd);
            chk("stall_last", 64'(o_m_tlast), 64'(hl));
         end
         if (o_m_tvalid && m_tready) begin
            cap[got] = o_m_tdata;
            chk("frame_data", o_m_tdata, word_of(ef[got]));
            chk("frame_last", 64'(o_m_tlast), 64'(got == NFFT - 1));
            got++;
            holding = 1'b0;
         end else if (o_m_tvalid) begin
            holding = 1'b1;
            hd = o_m_tdata;
            hl = o_m_tlast;
         end
         tick();
         budget++;
      end
      m_tready = 1'b0;
      chk("frame_words", 64'(got), 64'(nw));
      cycles = budget;
   endtask

   initial begin
      model_reset();
      #2 reset = 1'b0;
      tick();
      tick();
      chk("rst_cfg_tvalid", 64'(o_cfg_tvalid), 64'd1);
      chk("rst_cfg_tdata", 64'(o_cfg_tdata), 64'h0001);
      chk("rst_s_ready", 64'(o_s_ready), 64'd0);
      chk("rst_m_tvalid", 64'(o_m_tvalid), 64'd0);
      chk("rst_m_tlast", 64'(o_m_tlast), 64'd0);
      chk("rst_m_tdata", o_m_tdata, 64'd0);
      chk("rst_frame_count", 64'(o_frame_count), 64'd0);
      chk("rst_busy", 64'(o_busy), 64'd0);

      // Config handshake delayed by 5 cycles.
      reset = 1'b1;
      repeat (5) begin
         chk("cfg_hold", 64'(o_cfg_tvalid), 64'd1);
         chk("cfg_hold_sready", 64'(o_s_ready), 64'd0);
         tick();
      end
      cfg_tready = 1'b1;
      chk("cfg_sixth", 64'(o_cfg_tvalid), 64'd1);
      chk("cfg_tdata", 64'(o_cfg_tdata), 64'h0001);
      tick();
      chk("cfg_drop", 64'(o_cfg_tvalid), 64'd0);
      chk("s_ready_rise", 64'(o_s_ready), 64'd1);

      // First frame: samples 1..8, full throughput.
      for (int i = 1; i <= 8; i++) push(16'(i));
      chk("busy_on_last_write", 64'(o_busy), 64'd1);
      chk("s_ready_in_stream", 64'(o_s_ready), 64'd0);
      m_tready = 1'b1;
      tick();
      tick();
      chk("first_valid_latency", 64'(o_m_tvalid), 64'd1);
      collect(8, 1'b0, cyc);
      chk("throughput_cycles", 64'(cyc), 64'd8);
      chk("frame_count_1", 64'(o_frame_count), 64'd1);
      chk("back_to_fill", 64'(o_s_ready), 64'd1);
      chk("idle_m_tvalid", 64'(o_m_tvalid), 64'd0);

      // Overlapped frame: samples 9..12 give 5..12.
      for (int i = 9; i <= 12; i++) push(16'(i));
      collect(8, 1'b0, cyc);
      chk("overlap_first_word", cap[0], 64'(word_of(stored(16'd5, 16'd4))));
      chk("frame_count_2", 64'(o_frame_count), 64'd2);

      // Random back-pressure over 20 frames.
      for (int f = 0; f < 20; f++) begin
         for (int k = 0; k < 4; k++) push(16'($urandom_range(0, 65535)));
         collect(8, 1'b1, cyc);
      end
      chk("frame_count_22", 64'(o_frame_count), 64'd22);

      // Reset in the middle of a frame.
      for (int k = 0; k < 4; k++) push(16'($urandom_range(0, 65535)));
      collect(3, 1'b0, cyc);
      chk("midframe_pending", 64'(o_m_tvalid), 64'd1);
      #2 reset = 1'b0;
      #1;
      chk("arst_m_tvalid", 64'(o_m_tvalid), 64'd0);
      chk("arst_m_tdata", o_m_tdata, 64'd0);
      chk("arst_cfg_tvalid", 64'(o_cfg_tvalid), 64'd1);
      chk("arst_busy", 64'(o_busy), 64'd0);
      chk("arst_frame_count", 64'(o_frame_count), 64'd0);
      chk("arst_s_ready", 64'(o_s_ready), 64'd0);
      #1 reset = 1'b1;
      model_reset();
      tick();
      chk("post_rst_cfg_done", 64'(o_s_ready), 64'd1);
      push(16'h7FFF);
      push(16'h7FFF);
      push(16'h8000);
      for (int i = 1; i <= 4; i++) push(16'(i));
      chk("unprimed_still_fill", 64'(o_busy), 64'd0);
      push(16'd5);
      chk("fresh_frame_stream", 64'(o_busy), 64'd1);
      collect(8, 1'b0, cyc);
      chk("fresh_word0", cap[0], 64'h0000_0000_0000_7FFF);
`ifdef FRAMER_PREEMPH_EN
      chk("fresh_word1", cap[1], 64'h0000_0000_0000_03FF);
`else
      chk("fresh_word1", cap[1], 64'h0000_0000_0000_7FFF);
`endif
      chk("fresh_word2", cap[2], 64'h0000_0000_FFFF_8000);
      chk("frame_count_after_rst", 64'(o_frame_count), 64'd1);

      // Instance B: HOP = NFFT, negative samples, no overlap.
      sel = 1'b1;
      model_reset();
      for (int v = -3; v <= 4; v++) push(16'(v));
      collect(8, 1'b0, cyc);
      chk("sext_word0", cap[0], 64'h0000_0000_FFFF_FFFD);
      for (int v = 5; v <= 12; v++) push(16'(v));
      collect(8, 1'b0, cyc);
      chk("b_frame_count", 64'(o_frame_count), 64'd2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
